// File: rtl/jtag_scan_master_if.sv
// Request/response bundle between a scan client and jtag_scan_master.
// The master modport is the requester; the slave modport is the scan engine.
interface jtag_scan_master_if #(
    parameter int unsigned DR_MAX = 256,
    parameter int unsigned LEN_W  = 9
) ();
    logic              req_valid;
    logic [1:0]        req_op;
    logic [LEN_W-1:0]  req_len;
    logic [DR_MAX-1:0] req_data;
    logic              req_ready;
    logic              rsp_valid;
    logic              rsp_err;
    logic [DR_MAX-1:0] rsp_data;

    modport master (
        output req_valid, req_op, req_len, req_data,
        input  req_ready, rsp_valid, rsp_err, rsp_data
    );

    modport slave (
        input  req_valid, req_op, req_len, req_data,
        output req_ready, rsp_valid, rsp_err, rsp_data
    );
endinterface

// File: rtl/jtag_scan_master.sv
// JTAG scan master: drives TMS/TDI from Run-Test/Idle for DR/IR scans, TAP reset and
// idle runs, capturing TDO during shift cycles into rsp_data.
module jtag_scan_master #(
    parameter int unsigned IR_LEN = 2,
    parameter int unsigned DR_MAX = 256,
    parameter int unsigned LEN_W  = 9
) (
    input  logic              TCLK,
    input  logic              TRST,
    output logic              TMS,
    output logic              TDI,
    input  logic              TDO,
    jtag_scan_master_if.slave bus
);
    typedef enum logic [2:0] {
        StTlr,
        StTlrExit,
        StIdle,
        StPre,
        StShift,
        StPost1,
        StPost2,
        StRun
    } state_e;

    localparam logic [1:0] OpDr  = 2'b00;
    localparam logic [1:0] OpIr  = 2'b01;
    localparam logic [1:0] OpRst = 2'b10;

    localparam logic [LEN_W-1:0] DrMaxL = LEN_W'(DR_MAX);
    localparam logic [LEN_W-1:0] IrLenL = LEN_W'(IR_LEN);

    state_e            state_q;
    logic [LEN_W-1:0]  cnt_q;
    logic [LEN_W-1:0]  len_q;
    logic [2:0]        pre_q;
    logic [DR_MAX-1:0] data_q;
    logic [DR_MAX-1:0] cap_q;
    logic [DR_MAX-1:0] rsp_data_q;
    logic              tms_q;
    logic              tdi_q;
    logic              ready_q;
    logic              rsp_valid_q;
    logic              rsp_err_q;
    logic              tlr_rsp_q;
    logic              dr_bad;

    assign dr_bad = (bus.req_len == '0) || (bus.req_len > DrMaxL);

    always_ff @(posedge TCLK or negedge TRST) begin
        if (!TRST) begin
            state_q     <= StTlr;
            cnt_q       <= '0;
            len_q       <= '0;
            pre_q       <= '0;
            data_q      <= '0;
            cap_q       <= '0;
            rsp_data_q  <= '0;
            tms_q       <= 1'b1;
            tdi_q       <= 1'b0;
            ready_q     <= 1'b0;
            rsp_valid_q <= 1'b0;
            rsp_err_q   <= 1'b0;
            tlr_rsp_q   <= 1'b0;
        end else begin
            rsp_valid_q <= 1'b0;
            rsp_err_q   <= 1'b0;
            unique case (state_q)
                // Shared by TRST release and the TAP-reset request: five TMS=1, one TMS=0.
                StTlr: begin
                    if (cnt_q == LEN_W'(4)) begin
                        tms_q   <= 1'b0;
                        state_q <= StTlrExit;
                    end else begin
                        cnt_q <= cnt_q + LEN_W'(1);
                    end
                end
                StTlrExit: begin
                    ready_q     <= 1'b1;
                    rsp_valid_q <= tlr_rsp_q;
                    state_q     <= StIdle;
                end
                StIdle: begin
                    if (bus.req_valid) begin
                        len_q     <= bus.req_len;
                        data_q    <= bus.req_data;
                        cnt_q     <= '0;
                        tlr_rsp_q <= 1'b1;
                        ready_q   <= 1'b0;
                        unique case (bus.req_op)
                            OpDr: begin
                                if (dr_bad) begin
                                    ready_q     <= 1'b1;
                                    rsp_valid_q <= 1'b1;
                                    rsp_err_q   <= 1'b1;
                                end else begin
                                    tms_q   <= 1'b1;
                                    pre_q   <= 3'b000;
                                    cnt_q   <= LEN_W'(2);
                                    state_q <= StPre;
                                end
                            end
                            OpIr: begin
                                len_q   <= IrLenL;
                                tms_q   <= 1'b1;
                                pre_q   <= 3'b001;
                                cnt_q   <= LEN_W'(3);
                                state_q <= StPre;
                            end
                            OpRst: begin
                                tms_q   <= 1'b1;
                                state_q <= StTlr;
                            end
                            default: begin
                                if (bus.req_len == '0) begin
                                    ready_q     <= 1'b1;
                                    rsp_valid_q <= 1'b1;
                                end else begin
                                    tms_q   <= 1'b0;
                                    cnt_q   <= bus.req_len - LEN_W'(1);
                                    state_q <= StRun;
                                end
                            end
                        endcase
                    end
                end
                // pre_q holds the remaining header TMS bits, LSB next.
                StPre: begin
                    if (cnt_q != '0) begin
                        tms_q <= pre_q[0];
                        pre_q <= pre_q >> 1;
                        cnt_q <= cnt_q - LEN_W'(1);
                    end else begin
                        tms_q   <= (len_q == LEN_W'(1));
                        tdi_q   <= data_q[0];
                        data_q  <= data_q >> 1;
                        state_q <= StShift;
                    end
                end
                StShift: begin
                    cap_q <= {TDO, cap_q[DR_MAX-1:1]};
                    if (cnt_q == len_q - LEN_W'(1)) begin
                        tms_q   <= 1'b1;
                        tdi_q   <= 1'b0;
                        state_q <= StPost1;
                    end else begin
                        cnt_q  <= cnt_q + LEN_W'(1);
                        tdi_q  <= data_q[0];
                        data_q <= data_q >> 1;
                        tms_q  <= (cnt_q + LEN_W'(2) == len_q);
                    end
                end
                StPost1: begin
                    tms_q   <= 1'b0;
                    state_q <= StPost2;
                end
                StPost2: begin
                    ready_q     <= 1'b1;
                    rsp_valid_q <= 1'b1;
                    // Captured bits entered at the top; align bit 0 and zero the rest.
                    rsp_data_q  <= cap_q >> (DrMaxL - len_q);
                    state_q     <= StIdle;
                end
                StRun: begin
                    if (cnt_q == '0) begin
                        ready_q     <= 1'b1;
                        rsp_valid_q <= 1'b1;
                        state_q     <= StIdle;
                    end else begin
                        cnt_q <= cnt_q - LEN_W'(1);
                    end
                end
                default: state_q <= StTlr;
            endcase
        end
    end

    assign TMS           = tms_q;
    assign TDI           = tdi_q;
    assign bus.req_ready = ready_q;
    assign bus.rsp_valid = rsp_valid_q;
    assign bus.rsp_err   = rsp_err_q;
    assign bus.rsp_data  = rsp_data_q;
endmodule

// File: tb/tb_jtag_scan_master.sv
// Bench for jtag_scan_master: directed and random requests against a sequence-level model;
// a monitor checks pins every cycle and pops expected responses from a scoreboard.
module tb_jtag_scan_master;
    localparam int IR_LEN = 2;
    localparam int DR_MAX = 256;
    localparam int LEN_W  = 9;

    typedef struct {
        int             done_cyc;
        bit             err;
        bit             chk_data;
        logic [255:0]   data;
    } exp_t;

    logic tclk = 1'b0;
    logic trst = 1'b1;
    logic tms, tdi, tdo;
    logic tdo_loop = 1'b0;
    logic [1023:0] tdo_tab;
    bit   loop_mode = 1'b0;
    bit   in_reset = 1'b1;
    int   edge_cnt = 0;
    int   n_checks = 0;
    int   n_pass = 0;
    exp_t sb[$];
    logic [2:0] exp_pin [int];   // {tms, tdi, req_ready} per cycle
    logic [255:0] model_rsp = '0;

    jtag_scan_master_if #(.DR_MAX(DR_MAX), .LEN_W(LEN_W)) bus ();

    jtag_scan_master #(.IR_LEN(IR_LEN), .DR_MAX(DR_MAX), .LEN_W(LEN_W)) dut (
        .TCLK (tclk),
        .TRST (trst),
        .TMS  (tms),
        .TDI  (tdi),
        .TDO  (tdo),
        .bus  (bus)
    );

    always #5 tclk = ~tclk;
    always @(posedge tclk) edge_cnt <= edge_cnt + 1;
    always @(posedge tclk) tdo_loop <= tdi;
    // TDO during cycle k is tdo_tab[k mod 1024] (or TDI delayed one cycle in loop mode).
    assign tdo = loop_mode ? tdo_loop : tdo_tab[10'(edge_cnt + 1)];

    task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    task automatic fail(input string name, input int limit);
        n_checks++;
        $display("FAIL %s: event not seen, required within %0d cycles", name, limit);
    endtask

    function automatic void model_push(input logic [1:0] op, input int len,
                                       input logic [255:0] data, input int a);
        exp_t e;
        bit   tms_s[$];
        bit   tdi_s[$];
        int   n = 0;
        int   base = 0;
        e.err = 1'b0;
        e.chk_data = 1'b1;
        e.data = model_rsp;
        case (op)
            2'b00: begin
                if (len == 0 || len > DR_MAX) e.err = 1'b1;
                else begin
                    n = len;
                    base = a + 4;
                    for (int k = 0; k < 3; k++) begin tms_s.push_back(k == 0); tdi_s.push_back(0); end
                end
            end
            2'b01: begin
                n = IR_LEN;
                base = a + 5;
                for (int k = 0; k < 4; k++) begin tms_s.push_back(k < 2); tdi_s.push_back(0); end
            end
            2'b10: begin
                for (int k = 0; k < 6; k++) begin tms_s.push_back(k < 5); tdi_s.push_back(0); end
            end
            default: begin
                e.chk_data = 1'b0;
                for (int k = 0; k < len; k++) begin tms_s.push_back(0); tdi_s.push_back(0); end
            end
        endcase
        if (n > 0) begin
            for (int i = 0; i < n; i++) begin tms_s.push_back(i == n - 1); tdi_s.push_back(data[i]); end
            tms_s.push_back(1); tdi_s.push_back(0);
            tms_s.push_back(0); tdi_s.push_back(0);
        end
        for (int k = 0; k < tms_s.size(); k++) exp_pin[a + 1 + k] = {tms_s[k], tdi_s[k], 1'b0};
        e.done_cyc = a + 1 + tms_s.size();
        if (n > 0) begin
            e.data = '0;
            for (int i = 0; i < n; i++)
                e.data[i] = loop_mode ? exp_pin[base + i - 1][1] : tdo_tab[10'(base + i)];
            model_rsp = e.data;
        end
        sb.push_back(e);
    endfunction

    always @(negedge tclk) begin : monitor
        exp_t e;
        int cyc;
        logic [2:0] ep;
        cyc = edge_cnt + 1;
        if (in_reset) begin
            check("trst_outputs", 256'({tms, tdi, bus.req_ready, bus.rsp_valid, bus.rsp_err}),
                  256'(5'b10000));
            check("trst_rsp_data", bus.rsp_data, '0);
        end else begin
            ep = exp_pin.exists(cyc) ? exp_pin[cyc] : 3'b001;
            check($sformatf("pins(tms,tdi,ready)@%0d", cyc),
                  256'({tms, tdi, bus.req_ready}), 256'(ep));
            if (bus.rsp_valid) begin
                if (sb.size() == 0) begin
                    check("unexpected_rsp_valid", 256'(bus.rsp_valid), '0);
                end else begin
                    e = sb.pop_front();
                    check("rsp_cycle", 256'(cyc), 256'(e.done_cyc));
                    check("rsp_err", 256'(bus.rsp_err), 256'(e.err));
                    if (e.chk_data) check("rsp_data", bus.rsp_data, e.data);
                end
            end else if (sb.size() != 0 && cyc > sb[0].done_cyc) begin
                fail("rsp_timeout", sb[0].done_cyc);
                void'(sb.pop_front());
            end
        end
    end

    task automatic issue(input logic [1:0] op, input int len, input logic [255:0] data,
                         output int acc);
        int waited = 0;
        @(negedge tclk);
        bus.req_valid = 1'b1;
        bus.req_op    = op;
        bus.req_len   = LEN_W'(len);
        bus.req_data  = data;
        while (!bus.req_ready && waited < 2000) begin
            @(negedge tclk);
            waited++;
        end
        if (!bus.req_ready) begin
            fail("accept_timeout", 2000);
            bus.req_valid = 1'b0;
            acc = -1;
            return;
        end
        acc = edge_cnt + 1;
        model_push(op, len, data, acc);
        @(posedge tclk);
    endtask

    task automatic idle_req();
        @(negedge tclk);
        bus.req_valid = 1'b0;
    endtask

    task automatic wait_done();
        int n = 0;
        while (sb.size() != 0 && n < 3000) begin
            @(negedge tclk);
            n++;
        end
        if (sb.size() != 0) fail("done_timeout", 3000);
    endtask

    // Called just after a falling clock edge, away from the active edge.
    task automatic assert_trst();
        #2 trst = 1'b0;
        in_reset = 1'b1;
        sb.delete();
        exp_pin.delete();
        model_rsp = '0;
        #1 check("trst_async", 256'({tms, tdi, bus.req_ready, bus.rsp_valid}), 256'(4'b1000));
    endtask

    task automatic release_trst();
        int e;
        #2 trst = 1'b1;
        e = edge_cnt;
        for (int k = 1; k <= 5; k++) exp_pin[e + k] = 3'b100;
        exp_pin[e + 6] = 3'b000;
        in_reset = 1'b0;
    endtask

    function automatic logic [255:0] rand_data();
        logic [255:0] d;
        for (int w = 0; w < 8; w++) d[w*32 +: 32] = $urandom;
        return d;
    endfunction

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation did not finish, required under 5000000 time units");
        $fatal(1);
    end

    initial begin
        int a1, a2, acc;
        logic [1:0] op;
        int len;
        for (int w = 0; w < 32; w++) tdo_tab[w*32 +: 32] = $urandom;
        bus.req_valid = 1'b0;
        bus.req_op    = 2'b00;
        bus.req_len   = '0;
        bus.req_data  = '0;
        #1 trst = 1'b0;
        repeat (3) @(negedge tclk);
        release_trst();
        repeat (10) @(negedge tclk);

        // IR scan, data 2'b10
        issue(2'b01, 0, 256'b10, acc); idle_req(); wait_done();
        // DR scan of 36 bits with TDO looped back through a register
        loop_mode = 1'b1;
        issue(2'b00, 36, 256'hdead0beef, acc); idle_req(); wait_done();
        loop_mode = 1'b0;
        // rejected DR lengths
        issue(2'b00, 0, rand_data(), acc); idle_req(); wait_done();
        issue(2'b00, 257, rand_data(), acc); idle_req(); wait_done();
        // idle run 10 then DR 4 accepted in its response cycle
        issue(2'b11, 10, '0, a1);
        issue(2'b00, 4, rand_data(), a2);
        idle_req(); wait_done();
        check("b2b_accept_gap", 256'(a2 - a1), 256'(11));
        // TAP reset, zero-length run, full-width DR
        issue(2'b10, 0, '0, acc); idle_req(); wait_done();
        issue(2'b11, 0, '0, acc); idle_req(); wait_done();
        issue(2'b00, DR_MAX, rand_data(), acc); idle_req(); wait_done();
        issue(2'b00, 1, rand_data(), acc); idle_req(); wait_done();

        // TRST during shift cycle 20 of a 211-bit DR scan
        issue(2'b00, 211, rand_data(), acc);
        idle_req();
        while (edge_cnt < acc + 23) @(negedge tclk);
        assert_trst();
        repeat (2) @(negedge tclk);
        release_trst();
        repeat (12) @(negedge tclk);

        for (int i = 0; i < 40; i++) begin
            op = 2'($urandom_range(0, 3));
            len = (op == 2'b11) ? $urandom_range(0, 20) : $urandom_range(0, 300);
            issue(op, len, rand_data(), acc);
            if ($urandom_range(0, 2) == 0) begin
                idle_req();
                repeat ($urandom_range(1, 4)) @(negedge tclk);
            end
        end
        idle_req();
        wait_done();
        repeat (3) @(negedge tclk);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
